// File: rtl/match_event_monitor.sv
// match_event_monitor: counts detector matches over a lifetime and per window,
// raises a latched alarm on busy windows and hands window counts downstream.
module match_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             alarm_clr,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] win_count,
  output logic             alarm,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [CNT_W-1:0] snap_data,
  output logic             overrun
);

  localparam int TW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;
  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ALARM
  } state_t;

  state_t           state_q, state_d;
  logic             match_q;
  logic [TW-1:0]    timer_q;
  logic             active;
  logic             close;
  logic             hit;
  logic [CNT_W-1:0] final_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             b
  );
    return (b && v != C_MAX) ? v + CNT_W'(1) : v;
  endfunction

  assign active    = (state_q != IDLE);
  assign close     = active && (timer_q == T_LAST) && !clear;
  assign final_cnt = sat_inc(win_count, match_q);
  assign hit       = close && (final_cnt >= THR);

  // next-state: a qualifying close beats alarm_clr, disable beats all
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = COUNT;
      COUNT:   if (hit) state_d = ALARM;
      ALARM:   if (alarm_clr && !hit) state_d = COUNT;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // state, registered alarm and input sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      alarm   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm   <= (state_d == ALARM);
      match_q <= match_in;
    end
  end

  // lifetime counter, window counter and window timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_count <= '0;
      win_count   <= '0;
      timer_q     <= '0;
    end else if (clear) begin
      total_count <= '0;
      win_count   <= '0;
      timer_q     <= '0;
    end else begin
      if (active) total_count <= sat_inc(total_count, match_q);
      if (state_d == IDLE) begin
        win_count <= '0;
        timer_q   <= '0;
      end else if (close) begin
        win_count <= '0;
        timer_q   <= '0;
      end else if (active) begin
        win_count <= final_cnt;
        timer_q   <= timer_q + TW'(1);
      end
    end
  end

  // snapshot port: load on close if free or draining, else flag overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
      overrun    <= 1'b0;
    end else if (clear) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
      overrun    <= 1'b0;
    end else if (close) begin
      if (!snap_valid || snap_ready) begin
        snap_data  <= final_cnt;
        snap_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (snap_valid && snap_ready) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_match_event_monitor.sv
// tb_match_event_monitor: directed stimulus with a snapshot scoreboard
// checked on every handshake, plus direct checks of the other outputs.
module tb_match_event_monitor;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             match_in;
  logic             enable;
  logic             clear;
  logic             alarm_clr;
  logic [CNT_W-1:0] total_count;
  logic [CNT_W-1:0] win_count;
  logic             alarm;
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] snap_data;
  logic             overrun;

  int vectors;
  int miscompares;
  int exp_q[$];

  match_event_monitor #(
    .CNT_W  (CNT_W),
    .WIN_LEN(8),
    .THRESH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .match_in   (match_in),
    .enable     (enable),
    .clear      (clear),
    .alarm_clr  (alarm_clr),
    .total_count(total_count),
    .win_count  (win_count),
    .alarm      (alarm),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic m);
    match_in = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_total"}, int'(total_count), 0);
    chk({tag, "_win"}, int'(win_count), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_valid"}, int'(snap_valid), 0);
    chk({tag, "_data"}, int'(snap_data), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // snapshot monitor: every accepted transfer must match the scoreboard
  always @(negedge clk) begin
    if (reset && snap_valid && snap_ready && !clear) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL snap_xfer: got %0d expected none", snap_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(snap_data) != e) begin
          miscompares++;
          $display("FAIL snap_xfer: got %0d expected %0d", snap_data, e);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    alarm_clr   = 1'b0;
    snap_ready  = 1'b0;
    match_in    = 1'b0;

    for (int i = 0; i < 4; i++) cyc(i % 2 == 0);
    chk_zero("rst");
    reset = 1'b1;
    repeat (5) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    chk("idle_total", int'(total_count), 0);
    chk("idle_win", int'(win_count), 0);

    exp_q.push_back(3);
    enable = 1'b1;
    cyc(1); cyc(0); cyc(1); cyc(0);
    cyc(1); cyc(0); cyc(0); cyc(0);
    chk("w1_win", int'(win_count), 3);
    chk("w1_alarm_pre", int'(alarm), 0);
    cyc(0);
    chk("w1_alarm", int'(alarm), 1);
    chk("w1_valid", int'(snap_valid), 1);
    chk("w1_data", int'(snap_data), 3);
    chk("w1_total", int'(total_count), 3);
    chk("w1_win_clr", int'(win_count), 0);
    alarm_clr = 1'b1;
    cyc(0);
    alarm_clr = 1'b0;
    chk("aclr_alarm", int'(alarm), 0);
    snap_ready = 1'b1;
    cyc(0);
    snap_ready = 1'b0;
    chk("hs1_valid", int'(snap_valid), 0);

    exp_q.push_back(2);
    cyc(1); cyc(0); cyc(1); cyc(0); cyc(0); cyc(0);
    chk("w2_alarm", int'(alarm), 0);
    chk("w2_valid", int'(snap_valid), 1);
    chk("w2_data", int'(snap_data), 2);
    chk("w2_total", int'(total_count), 5);
    snap_ready = 1'b1;
    cyc(0);
    snap_ready = 1'b0;
    chk("hs2_valid", int'(snap_valid), 0);

    enable = 1'b0;
    cyc(0);
    enable     = 1'b1;
    snap_ready = 1'b1;
    exp_q.push_back(8);
    exp_q.push_back(8);
    repeat (8) cyc(1);
    chk("sat_win7", int'(win_count), 7);
    cyc(1);
    chk("sat_alarm", int'(alarm), 1);
    chk("sat_valid", int'(snap_valid), 1);
    chk("sat_data", int'(snap_data), 8);
    repeat (11) cyc(1);
    chk("sat_total", int'(total_count), 15);
    repeat (3) cyc(1);
    chk("sat_hold", int'(total_count), 15);
    chk("sat_ovr", int'(overrun), 0);

    snap_ready = 1'b0;
    enable     = 1'b0;
    clear      = 1'b1;
    cyc(0);
    clear = 1'b0;
    chk("clr1_total", int'(total_count), 0);

    enable = 1'b1;
    repeat (4) cyc(1);
    repeat (5) cyc(0);
    chk("ov_alarm1", int'(alarm), 1);
    chk("ov_valid1", int'(snap_valid), 1);
    chk("ov_data1", int'(snap_data), 4);
    chk("ov_ovr0", int'(overrun), 0);
    cyc(1);
    repeat (7) cyc(0);
    chk("ov_ovr1", int'(overrun), 1);
    chk("ov_hold", int'(snap_data), 4);
    chk("ov_valid2", int'(snap_valid), 1);
    chk("ov_alarm2", int'(alarm), 1);

    clear = 1'b1;
    cyc(0);
    clear = 1'b0;
    chk("clr_alarm", int'(alarm), 1);
    chk("clr_total", int'(total_count), 0);
    chk("clr_win", int'(win_count), 0);
    chk("clr_valid", int'(snap_valid), 0);
    chk("clr_data", int'(snap_data), 0);
    chk("clr_ovr", int'(overrun), 0);

    exp_q.push_back(3);
    exp_q.push_back(4);
    repeat (3) cyc(1);
    repeat (5) cyc(0);
    chk("w3_valid", int'(snap_valid), 1);
    chk("w3_data", int'(snap_data), 3);
    repeat (4) cyc(1);
    repeat (3) cyc(0);
    alarm_clr  = 1'b1;
    snap_ready = 1'b1;
    cyc(0);
    alarm_clr = 1'b0;
    chk("sim_alarm", int'(alarm), 1);
    chk("sim_valid", int'(snap_valid), 1);
    chk("sim_data", int'(snap_data), 4);
    chk("sim_ovr", int'(overrun), 0);
    cyc(0);
    snap_ready = 1'b0;
    chk("sim_drain", int'(snap_valid), 0);

    enable = 1'b0;
    clear  = 1'b1;
    cyc(0);
    clear  = 1'b0;
    enable = 1'b1;
    cyc(1); cyc(1); cyc(0); cyc(0); cyc(0);
    chk("pre_rst_win", int'(win_count), 2);
    chk("pre_rst_total", int'(total_count), 2);
    #2 reset = 1'b0;
    #1;
    chk_zero("async");
    @(posedge clk);
    #1 reset = 1'b1;

    exp_q.push_back(1);
    cyc(0); cyc(0); cyc(1);
    repeat (5) cyc(0);
    chk("rw_early", int'(snap_valid), 0);
    cyc(0);
    chk("rw_valid", int'(snap_valid), 1);
    chk("rw_data", int'(snap_data), 1);
    chk("rw_alarm", int'(alarm), 0);
    snap_ready = 1'b1;
    cyc(0);
    snap_ready = 1'b0;
    chk("rw_drain", int'(snap_valid), 0);

    chk("sb_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_event_monitor.md
# match_event_monitor

Downstream consumer of the sequence detector's one-bit match output. Counts detected matches over a lifetime total and over fixed-length windows. Raises a latched alarm when a window's match count reaches a threshold. Hands each completed window count to the next stage through a valid/ready snapshot port.

## Interface
- CNT_W, default 8: width of all match counters and snapshot data.
- WIN_LEN, default 16: window length in clock cycles; legal range 2..2^16.
- THRESH, default 3: window match count that triggers the alarm; legal range 1..2^CNT_W-1.

Ports:
- clk, input, 1: single clock, rising-edge.
- reset, input, 1: asynchronous, active-low (0 = reset).
- match_in, input, 1: detector output; each cycle it is high counts as one match.
- enable, input, 1: monitoring enable.
- clear, input, 1: synchronous clear of counters and snapshot state.
- alarm_clr, input, 1: one-cycle request to leave the alarm state.
- total_count, output, CNT_W: lifetime match count; saturates.
- win_count, output, CNT_W: matches in the current window so far; saturates.
- alarm, output, 1: high while in the ALARM state.
- snap_valid, output, 1: a snapshot is pending.
- snap_ready, input, 1: the consumer accepts the snapshot.
- snap_data, output, CNT_W: count of the completed window.
- overrun, output, 1: sticky flag; a window closed while a snapshot was still pending.

## Operation
- **Input sampling:** match_in is registered into match_q every cycle, in all states. Only match_q feeds the counters.
- **States:** IDLE, COUNT, ALARM.
  - Reset enters IDLE.
  - enable=1 in IDLE → COUNT.
  - enable=0 from any state → IDLE. Entering IDLE clears win_count, the window timer and the alarm. total_count and the snapshot port are held.
- **Window timer:** in COUNT and ALARM, the timer runs 0..WIN_LEN-1 and then wraps to 0. It starts at 0 on the first edge after leaving IDLE.
- **Counting:** in COUNT and ALARM, match_q=1 increments total_count and win_count.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - In IDLE, no counting occurs.
- **Window close:** occurs on the edge where timer==WIN_LEN-1.
  - final = win_count + match_q, saturated.
  - win_count becomes 0 at the same edge.
  - If final >= THRESH, the state becomes ALARM, or stays ALARM.
- **alarm_clr:** in ALARM, alarm_clr=1 → COUNT.
  - If a qualifying window closes on the same edge, ALARM wins and the state stays ALARM.
  - alarm_clr is ignored in other states.
- **Snapshot port, at window close:**
  - If snap_valid=0, or snap_ready=1 on that edge: snap_data ← final and snap_valid=1.
  - Otherwise snap_data and snap_valid are held and overrun is set.
- **Snapshot handshake:** a transfer completes on an edge where snap_valid=1 and snap_ready=1.
  - With no close on that edge, snap_valid drops to 0.
  - While snap_valid=1, snap_data is stable.
- **clear=1 (synchronous):**
  - Zeroes total_count, win_count, the timer, snap_valid, snap_data and overrun.
  - Does not change the state. It has priority over counting, window close and the handshake on the same edge.

## Timing
- **Reset values:** total_count=0, win_count=0, alarm=0, snap_valid=0, snap_data=0, overrun=0, match_q=0, state IDLE.
- **Reset assertion** mid-window or mid-handshake takes effect immediately (asynchronous). Deassertion is used synchronously.
- **Counting latency:** match_in high before edge k → match_q=1 after edge k → counters incremented after edge k+1. Total latency is 2 cycles.
- **Window close to outputs:** alarm and snap_valid are high after the close edge, so 0 extra cycles beyond it.
- **Snapshot contents:** a match sampled into match_q on the close edge − 1 is included in final. A match arriving on the close edge goes to the next window.
- **Throughput:** one snapshot per WIN_LEN cycles. The consumer has WIN_LEN cycles to accept before overrun.
- **Output registering:** all outputs are registers; there are no combinational paths from input to output.

## Test plan
Parameters for all tests: CNT_W=4, WIN_LEN=8, THRESH=3.

- **Reset and idle:** hold reset=0 with match_in toggling → all outputs 0. Release reset with enable=0 and 5 match pulses → total_count stays 0.
- **Alarm trigger and clear:** enable=1, 3 single-cycle match pulses in window 1 → at that window's close, alarm=1, snap_valid=1, snap_data=3. Pulse alarm_clr → alarm=0 the next cycle.
- **Below threshold, then handshake:** 2 matches in a window → alarm stays 0, snap_data=2. Assert snap_ready for 1 cycle → snap_valid=0.
- **Saturation:** match_in held high for 20 cycles → total_count=15 and stays 15. snap_data=8 per window, which does not saturate at WIN_LEN=8.
- **Overrun and simultaneous events:**
  - snap_ready=0 across two window closes → overrun=1 and snap_data holds the first window's value.
  - alarm_clr on the edge of a qualifying close → alarm stays 1.
  - snap_ready=1 on a close edge → new data is loaded, snap_valid stays 1 and overrun is not set.
- **Reset and clear mid-operation:**
  - Assert reset at timer=4 with win_count=2 → everything is 0 immediately. After release and enable, the next close occurs 8 cycles later.
  - clear during ALARM → counters and snapshot state are zeroed, alarm stays 1.
